// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator controller/plant interface.
package elevator_pkg;

  localparam logic [1:0] AC_STOP    = 2'b00;
  localparam logic [1:0] AC_UP      = 2'b10;
  localparam logic [1:0] AC_DOWN    = 2'b01;
  localparam logic [1:0] AC_ILLEGAL = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_UP    = 2'd1;
  localparam logic [1:0] S_DOWN  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    UP    = S_UP,
    DOWN  = S_DOWN,
    FAULT = S_FAULT
  } car_state_t;

endpackage

// File: rtl/elevator_floor_strobe.sv
// Floor-mark detection: one-cycle sensor pulse on arrival at a mark, plus last-floor register.
module elevator_floor_strobe
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int POS_W         = $clog2(2*TRAVEL_CYCLES+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos_next,
  input  logic             hold,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output floor_t           floor,
  output logic             at_floor
);

  localparam logic [POS_W-1:0] MARK1 = '0;
  localparam logic [POS_W-1:0] MARK2 = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] MARK3 = POS_W'(2*TRAVEL_CYCLES);

  logic [POS_W-1:0] pos_prev;
  logic             at1, at2, at3;
  logic             arrive;

  assign at1 = (pos_next == MARK1);
  assign at2 = (pos_next == MARK2);
  assign at3 = (pos_next == MARK3);
  // A pulse needs a real arrival: holding at a mark or a frozen car never strobes.
  assign arrive = (pos_next != pos_prev) && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_prev <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      floor    <= 2'd1;
      at_floor <= 1'b1;
    end else begin
      pos_prev <= pos_next;
      at_floor <= at1 | at2 | at3;
      s1       <= arrive & at1;
      s2       <= arrive & at2;
      s3       <= arrive & at3;
      if (arrive && at1) floor <= 2'd1;
      else if (arrive && at2) floor <= 2'd2;
      else if (arrive && at3) floor <= 2'd3;
    end
  end

endmodule

// File: rtl/elevator_car_model.sv
// Plant model of a 3-floor car: integrates motor commands into position and flags controller misuse.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter  int TRAVEL_CYCLES = 16,
  localparam int POS_W         = $clog2(2*TRAVEL_CYCLES+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ac,
  input  logic       doorOpen,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output floor_t     floor,
  output logic       at_floor,
  output logic       moving,
  output logic       fault
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(2*TRAVEL_CYCLES);

  car_state_t       state, state_next;
  logic [POS_W-1:0] pos, pos_next;
  logic             violation;
  logic             hold;

  // Overrun checks are made against the current position so pos can never wrap.
  always_comb begin
    violation = 1'b0;
    if (ac == AC_ILLEGAL)                 violation = 1'b1;
    if ((ac == AC_UP) && (pos == POS_TOP)) violation = 1'b1;
    if ((ac == AC_DOWN) && (pos == '0))    violation = 1'b1;
    if (doorOpen && (ac != AC_STOP))       violation = 1'b1;
    if (doorOpen && !at_floor)             violation = 1'b1;
  end

  assign hold = (state == FAULT) || violation;

  always_comb begin
    pos_next   = pos;
    state_next = state;
    if (hold) begin
      state_next = FAULT;
    end else begin
      case (ac)
        AC_UP: begin
          pos_next   = pos + 1'b1;
          state_next = UP;
        end
        AC_DOWN: begin
          pos_next   = pos - 1'b1;
          state_next = DOWN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pos    <= '0;
      moving <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_next;
      pos    <= pos_next;
      moving <= (pos_next != pos);
      fault  <= hold;
    end
  end

  elevator_floor_strobe #(
    .TRAVEL_CYCLES (TRAVEL_CYCLES),
    .POS_W         (POS_W)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .pos_next (pos_next),
    .hold     (hold),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .floor    (floor),
    .at_floor (at_floor)
  );

endmodule

// File: tb/tb_elevator_car_model.sv
// Self-checking bench for elevator_car_model: directed scenarios plus a randomized walk against a position model.
module tb_elevator_car_model;

  localparam int T   = 16;
  localparam int TOP = 2*T;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ac = 2'b00;
  logic       doorOpen = 1'b0;
  logic       s1, s2, s3, at_floor, moving, fault;
  logic [1:0] floor;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_pos;
  logic [1:0] m_floor;
  logic     m_moving, m_fault;
  logic [2:0] m_s;

  elevator_car_model #(.TRAVEL_CYCLES(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ac       (ac),
    .doorOpen (doorOpen),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .floor    (floor),
    .at_floor (at_floor),
    .moving   (moving),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  function automatic bit is_mark(input int p);
    return (p % T) == 0;
  endfunction

  function automatic logic [7:0] obs_vec();
    return {s3, s2, s1, floor, at_floor, moving, fault};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_s[2], m_s[1], m_s[0], m_floor, logic'(is_mark(m_pos)), m_moving, m_fault};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_floor = 2'd1; m_moving = 1'b0; m_fault = 1'b0; m_s = 3'b000;
  endtask

  task automatic model_step(input logic [1:0] a, input logic d);
    bit bad;
    int np;
    bad = (a == 2'b11) || (a == 2'b10 && m_pos == TOP) || (a == 2'b01 && m_pos == 0)
          || (d && a != 2'b00) || (d && !is_mark(m_pos));
    m_s = 3'b000;
    if (m_fault || bad) begin
      m_fault  = 1'b1;
      m_moving = 1'b0;
    end else begin
      np = m_pos + ((a == 2'b10) ? 1 : 0) - ((a == 2'b01) ? 1 : 0);
      m_moving = (np != m_pos);
      if (np != m_pos && is_mark(np)) begin
        m_s[np / T] = 1'b1;
        m_floor     = 2'(np / T + 1);
      end
      m_pos = np;
    end
  endtask

  // Apply inputs, take one rising edge, advance the model, settle 1 time unit past the edge.
  task automatic cyc(input logic [1:0] a, input logic d);
    ac = a;
    doorOpen = d;
    @(posedge clk);
    model_step(a, d);
    #1;
  endtask

  task automatic do_reset();
    ac = 2'b00;
    doorOpen = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec() !== 8'b000_01_1_0_0) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", obs_vec(), 8'b000_01_1_0_0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_up_run();
    int s2_edge = -1, s3_edge = -1, s2_cnt = 0, s3_cnt = 0;
    do_reset();
    for (int i = 1; i <= 2*T; i++) begin
      cyc(2'b10, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL up_run edge %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (s2) begin s2_edge = i; s2_cnt++; end
      if (s3) begin s3_edge = i; s3_cnt++; end
    end
    n_checks++;
    if (s2_edge != 16 || s2_cnt != 1) begin
      n_fail++;
      $display("FAIL up_run_s2: got edge %0d count %0d want edge 16 count 1", s2_edge, s2_cnt);
    end
    n_checks++;
    if (s3_edge != 32 || s3_cnt != 1 || floor !== 2'd3 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL up_run_s3: got edge %0d count %0d floor %0d fault %b want 32 1 3 0",
               s3_edge, s3_cnt, floor, fault);
    end
  endtask

  task automatic test_park();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(2'b10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(2'b00, 1'b0);
      if (s1 | s2 | s3) strobes++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL park cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (at_floor !== 1'b0 || moving !== 1'b0 || fault !== 1'b0 || strobes != 0) begin
      n_fail++;
      $display("FAIL park_final: got at_floor %b moving %b fault %b strobes %0d want 0 0 0 0",
               at_floor, moving, fault, strobes);
    end
  endtask

  task automatic test_reversal();
    int s1_edge = -1, s2_cnt = 0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc((i <= 5) ? 2'b10 : 2'b01, 1'b0);
      if (s1) s1_edge = i;
      if (s2) s2_cnt++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reversal edge %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (s1_edge != 10 || s2_cnt != 0 || floor !== 2'd1 || at_floor !== 1'b1) begin
      n_fail++;
      $display("FAIL reversal_final: got s1 edge %0d s2 %0d floor %0d at_floor %b want 10 0 1 1",
               s1_edge, s2_cnt, floor, at_floor);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < TOP; i++) cyc(2'b10, 1'b0);
    cyc(2'b10, 1'b0);
    n_checks++;
    if (fault !== 1'b1 || s3 !== 1'b0 || floor !== 2'd3 || at_floor !== 1'b1 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_edge: got %b want fault=1 s3=0 floor=3 at_floor=1 moving=0", obs_vec());
    end
    for (int i = 0; i < 5; i++) begin
      cyc((i % 2) ? 2'b01 : 2'b00, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || fault !== 1'b1) begin
        n_fail++;
        $display("FAIL overrun_sticky cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    do_reset();
    n_checks++;
    if (obs_vec() !== 8'b000_01_1_0_0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want %b", obs_vec(), 8'b000_01_1_0_0);
    end
  endtask

  task automatic test_door();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(2'b10, 1'b0);
    cyc(2'b00, 1'b1);
    n_checks++;
    if (fault !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL door_offfloor: got %b want %b", obs_vec(), exp_vec());
    end
    do_reset();
    for (int i = 0; i < T; i++) cyc(2'b10, 1'b0);
    cyc(2'b00, 1'b1);
    n_checks++;
    if (fault !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL door_legal: got %b want %b", obs_vec(), exp_vec());
    end
    cyc(2'b01, 1'b1);
    n_checks++;
    if (fault !== 1'b1 || floor !== 2'd2 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL door_moving: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(2'b10, 1'b0);
    n_checks++;
    if (at_floor !== 1'b0 || moving !== 1'b1 || floor !== 2'd2) begin
      n_fail++;
      $display("FAIL async_pre: got %b want at_floor=0 moving=1 floor=2", obs_vec());
    end
    ac = 2'b00;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (obs_vec() !== 8'b000_01_1_0_0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs_vec(), 8'b000_01_1_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 1'b0);
      n_checks++;
      if (s1 !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_release cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic       d;
    int         r;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        r = $urandom_range(0, 199);
        d = 1'b0;
        if (r == 0)       a = 2'b11;
        else if (r < 90)  a = 2'b10;
        else if (r < 160) a = 2'b01;
        else              a = 2'b00;
        if (r != 0 && r != 1) begin
          if (a == 2'b10 && m_pos == TOP) a = 2'b01;
          if (a == 2'b01 && m_pos == 0)   a = 2'b10;
        end
        if (a == 2'b00 && is_mark(m_pos) && $urandom_range(0, 1) == 1) d = 1'b1;
        if ($urandom_range(0, 199) == 0) d = 1'b1;
        cyc(a, d);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random r%0d c%0d ac=%b door=%b: got %b want %b",
                   round, i, a, d, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_run();
    test_park();
    test_reversal();
    test_overrun();
    test_door();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
